// File: rtl/gauss_5x5_filter.sv
// 5x5 separable Gaussian ([1 4 6 4 1] x [1 4 6 4 1]) over a streamed window, 3-cycle latency.
// Border windows pass the centre pixel through unfiltered.
module gauss_5x5_filter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [199:0] win_data,
    input  logic         in_valid,
    input  logic         sof,
    output logic [7:0]   pix_out,
    output logic         out_valid,
    output logic         out_sof
);

    localparam logic [9:0] COL_LAST = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] COL_HI   = 10'(IMG_WIDTH - 3);
    localparam logic [9:0] ROW_LAST = 10'(IMG_HEIGHT - 1);
    localparam logic [9:0] ROW_HI   = 10'(IMG_HEIGHT - 3);

    // Centre-pixel position counters
    logic [9:0] col;
    logic [9:0] row;
    logic [9:0] pos_col;
    logic [9:0] pos_row;
    logic       border;

    // Stage 1: horizontal sums
    logic [11:0] h_next [5];
    logic [11:0] s1_h   [5];
    logic [7:0]  s1_centre;
    logic        s1_valid;
    logic        s1_sof;
    logic        s1_border;

    // Stage 2: vertical sum
    logic [15:0] v_next;
    logic [15:0] s2_sum;
    logic [7:0]  s2_centre;
    logic        s2_valid;
    logic        s2_sof;
    logic        s2_border;

    logic [7:0]  filt_pix;

    function automatic logic [11:0] hsum(input logic [39:0] r);
        return 12'(r[39:32]) + 12'(r[7:0])
             + (12'(r[31:24]) + 12'(r[15:8])) * 12'd4
             + 12'(r[23:16]) * 12'd6;
    endfunction

    // A window accepted with sof is position (0,0) regardless of the running count.
    always_comb begin
        pos_col = sof ? '0 : col;
        pos_row = sof ? '0 : row;
        border  = (pos_col < 10'd2) || (pos_col > COL_HI) ||
                  (pos_row < 10'd2) || (pos_row > ROW_HI);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                row <= (pos_row == ROW_LAST) ? '0 : pos_row + 10'd1;
            end else begin
                col <= pos_col + 10'd1;
                row <= pos_row;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 5; i++) begin
            h_next[i] = hsum(win_data[199 - 40*i -: 40]);
        end
    end

    always_comb begin
        v_next = 16'(s1_h[0]) + 16'(s1_h[4])
               + (16'(s1_h[1]) + 16'(s1_h[3])) * 16'd4
               + 16'(s1_h[2]) * 16'd6;
        filt_pix = 8'((17'(s2_sum) + 17'd128) >> 8);
    end

    // Data path registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 5; i++) begin
            s1_h[i] <= h_next[i];
        end
        s1_centre <= win_data[103:96];
        s2_sum    <= v_next;
        s2_centre <= s1_centre;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_border <= 1'b0;
            s2_valid  <= 1'b0;
            s2_sof    <= 1'b0;
            s2_border <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            pix_out   <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_sof    <= in_valid & sof;
            s1_border <= in_valid & border;
            s2_valid  <= s1_valid;
            s2_sof    <= s1_valid & s1_sof;
            s2_border <= s1_valid & s1_border;
            out_valid <= s2_valid;
            out_sof   <= s2_valid & s2_sof;
            if (s2_valid) begin
                pix_out <= s2_border ? s2_centre : filt_pix;
            end
        end
    end

endmodule

// File: tb/tb_gauss_5x5_filter.sv
// Scoreboard bench for gauss_5x5_filter on an 8x6 image: driver queues expectations,
// monitor checks every output cycle for value, sof, latency and idle behaviour.
module tb_gauss_5x5_filter;

    logic         clk = 1'b0;
    logic         reset;
    logic [199:0] win_data;
    logic         in_valid;
    logic         sof;
    logic [7:0]   pix_out;
    logic         out_valid;
    logic         out_sof;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_exp = 0;

    int   due_q [$];
    int   pix_q [$];
    logic sof_q [$];

    gauss_5x5_filter #(
        .IMG_WIDTH (8),
        .IMG_HEIGHT(6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .win_data (win_data),
        .in_valid (in_valid),
        .sof      (sof),
        .pix_out  (pix_out),
        .out_valid(out_valid),
        .out_sof  (out_sof)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [199:0] pix_at(input int r, input int c, input logic [7:0] v);
        logic [199:0] w;
        w = '0;
        w[199 - 40*r - 8*c -: 8] = v;
        return w;
    endfunction

    function automatic logic [199:0] flat(input logic [7:0] v);
        return {25{v}};
    endfunction

    function automatic int impulse_filtered(input int c);
        return (c * 36 + 128) >> 8;
    endfunction

    function automatic bit interior(input int idx);
        int c;
        int r;
        c = idx % 8;
        r = (idx / 8) % 6;
        return (c >= 2) && (c <= 5) && (r >= 2) && (r <= 3);
    endfunction

    task automatic send(input logic [199:0] d, input logic s, input int ep);
        @(negedge clk);
        win_data = d;
        in_valid = 1'b1;
        sof      = s;
        due_q.push_back(cyc + 3);
        pix_q.push_back(ep);
        sof_q.push_back(s);
    endtask

    task automatic idle(input int n, input logic s);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            sof      = s;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (due_q.size() != 0 && k < 20) begin
            idle(1, 1'b0);
            k++;
        end
        idle(1, 1'b0);
        check("drain_pending", due_q.size(), 0);
    endtask

    // Monitor: samples 2 time units after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (reset) begin
                last_exp = 0;
                check("rst_out_valid", int'(out_valid), 0);
                check("rst_out_sof", int'(out_sof), 0);
                check("rst_pix_out", int'(pix_out), 0);
            end else begin
                while (due_q.size() != 0 && due_q[0] < cyc) begin
                    check("missing_output_due", cyc, due_q[0]);
                    void'(due_q.pop_front());
                    void'(pix_q.pop_front());
                    void'(sof_q.pop_front());
                end
                if (out_valid) begin
                    if (due_q.size() == 0) begin
                        check("unexpected_out_valid", int'(out_valid), 0);
                    end else begin
                        check("latency", cyc, due_q[0]);
                        check("pix_out", int'(pix_out), pix_q[0]);
                        check("out_sof", int'(out_sof), int'(sof_q[0]));
                        last_exp = pix_q[0];
                        void'(due_q.pop_front());
                        void'(pix_q.pop_front());
                        void'(sof_q.pop_front());
                    end
                end else begin
                    check("hold_pix_out", int'(pix_out), last_exp);
                    check("idle_out_sof", int'(out_sof), 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        sof      = 1'b0;
        win_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(2, 1'b0);

        // Frame 1: centre = index, others 0; runs past window 47 into the next frame
        for (int i = 0; i < 67; i++) begin
            send(pix_at(2, 2, 8'(i)), (i == 0), interior(i) ? impulse_filtered(i) : i);
        end

        // Frame 2: sof mid-count restarts at (0,0); special windows at interior slots
        for (int i = 0; i < 30; i++) begin
            if (i == 26) begin
                idle(2, 1'b1);
            end
            case (i)
                18:      send(flat(8'd100), 1'b0, 100);
                19:      send(pix_at(2, 2, 8'd255), 1'b0, 36);
                20:      send(flat(8'd255), 1'b0, 255);
                21:      send(pix_at(0, 0, 8'd255) | pix_at(1, 2, 8'd255), 1'b0, 25);
                26:      send(flat(8'd100), 1'b0, 100);
                27:      send(pix_at(4, 4, 8'd255) | pix_at(2, 0, 8'd255), 1'b0, 7);
                default: send(pix_at(2, 2, 8'(i)), (i == 0),
                              interior(i) ? impulse_filtered(i) : i);
            endcase
        end

        // Frame 3: sof again before frame 2 completes
        for (int i = 0; i < 21; i++) begin
            send(pix_at(2, 2, 8'(i + 100)), (i == 0),
                 interior(i) ? impulse_filtered(i + 100) : i + 100);
        end
        drain();

        // Mid-frame reset with windows in flight; the window under reset is dropped
        send(flat(8'd50), 1'b1, 50);
        send(flat(8'd60), 1'b0, 60);
        @(negedge clk);
        win_data = flat(8'd70);
        in_valid = 1'b1;
        sof      = 1'b1;
        reset    = 1'b1;
        due_q.delete();
        pix_q.delete();
        sof_q.delete();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        sof      = 1'b0;
        idle(3, 1'b0);
        send(flat(8'd77) | pix_at(2, 2, 8'd77), 1'b0, 77);
        send(pix_at(2, 2, 8'd78), 1'b0, 78);
        send(pix_at(2, 2, 8'd79), 1'b0, 79);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
